dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
Controller that sequences the DSP slice post-adder through a multiply-accumulate run of len products, with P = sum of M over the run. Per accepted operand pair, it steers the X-mux select (OPCODE_01) and Z-mux select (OPCODE_23) and the P clock-enable. Selects are aligned to the multiplier pipeline latency. Sits between the operand source (valid/ready stream) and the DSP slice OPMODE/CE inputs.

Parameters:
LEN_W, 8, width of run-length input and internal term counter
MUL_LAT, 2, cycles from operand acceptance to product at X-mux input; legal range 1..8

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  1-cycle run request; sampled only in IDLE
len  in  LEN_W  number of products in run; captured on accepted start
op_valid  in  1  operand pair (A, B) presented to the slice this cycle
op_ready  out  1  sequencer accepts operand this cycle
OPCODE_01  out  2  X-mux select: 0 = zero, 1 = M, 2 = PCOUT, 3 = D:A:B
OPCODE_23  out  2  Z-mux select: 0 = zero, 1 = PCIN, 2 = PCOUT, 3 = C
CE_M  out  1  M register enable, equal to op_valid & op_ready
CE_P  out  1  P register enable
busy  out  1  run in progress (start accepted through done)
done  out  1  1-cycle pulse; P holds final sum this cycle

Behaviour:
- Reset (async, RST_N=0): state IDLE; counter and token line cleared; OPCODE_01=0, OPCODE_23=2, CE_M=0, CE_P=0, op_ready=0, busy=0, done=0.
- All outputs are registered, except CE_M.
- States:
  - IDLE: start=1, len>0 -> ACCUM, busy=1. start=1, len=0 -> DONE directly; no CE_P.
  - ACCUM: op_ready=1. Each op_valid & op_ready decrements the remaining count. On the last acceptance, op_ready drops the next cycle -> DRAIN.
  - DRAIN: op_ready=0; wait until the token line is empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Token line: MUL_LAT-deep shift register of {valid, first}. It is written on each acceptance; first=1 only for the first term of the run.
- Control cycle (token leaving the line; occurs in cycle c+MUL_LAT for acceptance cycle c):
  - CE_P=1, OPCODE_01=1.
  - OPCODE_23=0 if first, else 2.
- Cycles with no exiting token: CE_P=0, OPCODE_01=0, OPCODE_23=2 (hold-safe).
- Bubbles: op_valid gaps stall only the count. P is untouched in gap cycles. Final sum is independent of gap pattern.
- done asserts in the cycle after the last control cycle.
- start while busy: ignored, no queueing. len is sampled only with an accepted start.
- len = max (2^LEN_W - 1): exact count; no wrap.
- Reset mid-run: immediate IDLE, token line flushed, no done pulse.

Optional Feature:
Macro SEQ_BIAS_PRELOAD_EN.
- Defined: the first term's control cycle uses OPCODE_23=3 (C), so P = C + sum M. With len=0, one control cycle is issued in the cycle after start, with OPCODE_01=0, OPCODE_23=3, CE_P=1; done follows the next cycle.
- Undefined: behaviour as above (first term Z=0); len=0 issues no CE_P.

Test Plan:
1. MUL_LAT=2, start len=3, op_valid high in cycles 1,2,3 -> control cycles 3,4,5 show (X,Z) = (1,0), (1,2), (1,2) with CE_P=1; done in cycle 6; busy low in cycle 7.
2. len=3, op_valid pattern 1,0,0,1,1 -> exactly 3 CE_P cycles, gaps show X=0, Z=2, CE_P=0; slice with A*B=5,7,11 ends with P=23 at done.
3. start with len=0 -> done the cycle after start, CE_P never asserted, op_ready never asserted.
4. RST_N low in cycle 4 of a len=5 run -> all outputs at reset values the same cycle; no done; a new start len=2 then completes normally.
5. start pulsed again while busy (len=9) -> ignored; run completes with the original len; CE_P count matches the original len.
6. SEQ_BIAS_PRELOAD_EN defined, C=100, products 2,3 -> first control cycle Z=3; P=105 at done. With len=0, P=100 at done.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP slice post-adder through a len-term multiply-accumulate run.
// Optional macro SEQ_BIAS_PRELOAD_EN: the first term adds C (Z=3), so P = C + sum M.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [1:0]       OPCODE_01,
  output logic [1:0]       OPCODE_23,
  output logic             CE_M,
  output logic             CE_P,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] X_ZERO  = 2'd0;
  localparam logic [1:0] X_M     = 2'd1;
  localparam logic [1:0] Z_PCOUT = 2'd2;
`ifdef SEQ_BIAS_PRELOAD_EN
  localparam logic [1:0] Z_FIRST = 2'd3;
`else
  localparam logic [1:0] Z_FIRST = 2'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             op_ready_d, busy_d, done_d, ce_p_d;
  logic [1:0]       op01_d, op23_d;

  logic accept;
  logic tok_in_v, tok_in_f;
  logic exit_v, exit_f;
  logic line_busy;

  assign accept   = op_valid & op_ready;
  assign CE_M     = accept;
  assign tok_in_v = accept;
  assign tok_in_f = accept & first_q;

  // Token line: the output register is the final stage, so MUL_LAT-1 stages sit in front of it.
  if (MUL_LAT == 1) begin : g_direct
    assign exit_v    = tok_in_v;
    assign exit_f    = tok_in_f;
    assign line_busy = 1'b0;
  end else begin : g_line
    localparam int unsigned D = MUL_LAT - 1;
    logic [D-1:0] tok_v, tok_f;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        tok_v <= '0;
        tok_f <= '0;
      end else begin
        tok_v[0] <= tok_in_v;
        tok_f[0] <= tok_in_f;
        for (int i = 1; i < int'(D); i++) begin
          tok_v[i] <= tok_v[i-1];
          tok_f[i] <= tok_f[i-1];
        end
      end
    end

    assign exit_v    = tok_v[D-1];
    assign exit_f    = tok_f[D-1];
    assign line_busy = |tok_v;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    op_ready_d = op_ready;
    busy_d     = busy;
    done_d     = 1'b0;
    ce_p_d     = exit_v;
    op01_d     = exit_v ? X_M : X_ZERO;
    op23_d     = (exit_v && exit_f) ? Z_FIRST : Z_PCOUT;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = len;
          first_d = 1'b1;
          if (len != '0) begin
            state_d    = S_ACCUM;
            op_ready_d = 1'b1;
          end else begin
`ifdef SEQ_BIAS_PRELOAD_EN
            // Bias-only run: a single C-load control cycle, then drain.
            state_d = S_DRAIN;
            ce_p_d  = 1'b1;
            op01_d  = X_ZERO;
            op23_d  = Z_FIRST;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_W'(1)) begin
            op_ready_d = 1'b0;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!line_busy) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      op_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      CE_P      <= 1'b0;
      OPCODE_01 <= X_ZERO;
      OPCODE_23 <= Z_PCOUT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      op_ready  <= op_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      CE_P      <= ce_p_d;
      OPCODE_01 <= op01_d;
      OPCODE_23 <= op23_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: scoreboard of expected control cycles plus a behavioural DSP slice
// driven by the DUT outputs, whose P is compared with the expected sum at done.
module tb_dsp_mac_sequencer;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned C_VAL   = 100;
`ifdef SEQ_BIAS_PRELOAD_EN
  localparam logic [1:0]  Z_FIRST = 2'd3;
  localparam bit          BIAS    = 1'b1;
`else
  localparam logic [1:0]  Z_FIRST = 2'd0;
  localparam bit          BIAS    = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       OPCODE_01;
  logic [1:0]       OPCODE_23;
  logic             CE_M;
  logic             CE_P;
  logic             busy;
  logic             done;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .op_valid(op_valid),
    .op_ready(op_ready), .OPCODE_01(OPCODE_01), .OPCODE_23(OPCODE_23),
    .CE_M(CE_M), .CE_P(CE_P), .busy(busy), .done(done)
  );

  typedef struct {
    int         due;
    logic [1:0] x;
    logic [1:0] z;
  } ctrl_t;

  ctrl_t       ctrl_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_done = -1;
  int          cep_count = 0;
  int          done_count = 0;
  int unsigned m_pipe[MUL_LAT];
  int unsigned p_model = 0;
  int unsigned exp_sum = 0;
  int unsigned prod_in = 0;
  int          phase = 0;
  int          rem = 0;
  logic        first = 1'b0;
  logic        e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_pchk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ctrl_q.delete();
    phase   = 0;
    e_ready = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_pchk  = 1'b0;
  endtask

  // Compare this cycle's outputs, then advance the slice and the expectation model.
  task automatic check();
    ctrl_t       c;
    int unsigned xv, zv;
    logic        nd, np;
    chk("op_ready", op_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("ce_m", CE_M, op_valid & e_ready);
    if (ctrl_q.size() > 0 && ctrl_q[0].due == cyc) begin
      c = ctrl_q.pop_front();
      chk("ce_p_ctrl", CE_P, 1);
      chk("x_ctrl", OPCODE_01, c.x);
      chk("z_ctrl", OPCODE_23, c.z);
    end else begin
      chk("ce_p_idle", CE_P, 0);
      chk("x_idle", OPCODE_01, 0);
      chk("z_idle", OPCODE_23, 2);
    end
    if (done === 1'b1) begin
      last_done = cyc;
      done_count++;
    end
    if (CE_P === 1'b1) cep_count++;
    if (e_done && e_pchk) chk("p_final", p_model, exp_sum);

    if (CE_P === 1'b1) begin
      case (OPCODE_01)
        2'd1:    xv = m_pipe[MUL_LAT-1];
        2'd2:    xv = p_model;
        default: xv = 0;
      endcase
      case (OPCODE_23)
        2'd2:    zv = p_model;
        2'd3:    zv = C_VAL;
        default: zv = 0;
      endcase
      p_model = xv + zv;
    end
    for (int i = MUL_LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = (CE_M === 1'b1) ? prod_in : 0;

    nd = 1'b0;
    np = e_pchk;
    case (phase)
      0: if (start) begin
        e_busy = 1'b1;
        if (len != 0) begin
          phase   = 1;
          rem     = int'(len);
          first   = 1'b1;
          e_ready = 1'b1;
          exp_sum = BIAS ? C_VAL : 0;
        end else if (BIAS) begin
          ctrl_q.push_back('{due: cyc + 1, x: 2'd0, z: 2'd3});
          exp_sum = C_VAL;
          phase   = 2;
        end else begin
          nd    = 1'b1;
          np    = 1'b0;
          phase = 3;
        end
      end
      1: if (op_valid && e_ready) begin
        ctrl_q.push_back('{due: cyc + MUL_LAT, x: 2'd1, z: first ? Z_FIRST : 2'd2});
        exp_sum += prod_in;
        first = 1'b0;
        rem--;
        if (rem == 0) begin
          e_ready = 1'b0;
          phase   = 2;
        end
      end
      2: if (ctrl_q.size() == 0) begin
        nd    = 1'b1;
        np    = 1'b1;
        phase = 3;
      end
      default: begin
        e_busy = 1'b0;
        phase  = 0;
      end
    endcase
    e_done = nd;
    e_pchk = np;
  endtask

  task automatic step(input logic s, input logic [LEN_W-1:0] l, input logic v, input int unsigned p);
    start    = s;
    len      = l;
    op_valid = v;
    prod_in  = p;
    @(negedge CLK);
    check();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic drain(input logic s, input logic [LEN_W-1:0] l);
    for (int i = 0; i < 40 && phase != 0; i++) step(s, l, 1'b0, 0);
  endtask

  int t0;
  int d0;

  initial begin
    for (int i = 0; i < MUL_LAT; i++) m_pipe[i] = 0;
    RST_N = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0;
    @(posedge CLK);
    #1;
    step(1'b0, '0, 1'b0, 0);
    RST_N = 1'b1;
    step(1'b0, '0, 1'b0, 0);

    // Back-to-back run of three terms: control cycles 3..5, done at 6, busy low at 7
    t0 = cyc; cep_count = 0;
    step(1'b1, 8'd3, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1);
    step(1'b0, '0, 1'b1, 2);
    step(1'b0, '0, 1'b1, 3);
    drain(1'b0, '0);
    chk("t1_done_offset", last_done - t0, 6);
    chk("t1_cep_count", cep_count, 3);
    step(1'b0, '0, 1'b0, 0);

    // Bubbles in the operand stream
    cep_count = 0;
    step(1'b1, 8'd3, 1'b0, 0);
    step(1'b0, '0, 1'b1, 5);
    step(1'b0, '0, 1'b0, 99);
    step(1'b0, '0, 1'b0, 99);
    step(1'b0, '0, 1'b1, 7);
    step(1'b0, '0, 1'b1, 11);
    drain(1'b0, '0);
    chk("t2_cep_count", cep_count, 3);
    chk("t2_p", p_model, BIAS ? 123 : 23);

    // Zero-length run
    t0 = cyc; cep_count = 0;
    step(1'b1, 8'd0, 1'b1, 4);
    drain(1'b0, '0);
    chk("t3_done_offset", last_done - t0, BIAS ? 2 : 1);
    chk("t3_cep_count", cep_count, BIAS ? 1 : 0);
    if (BIAS) chk("t3_p", p_model, C_VAL);
    step(1'b0, '0, 1'b0, 0);

    // Reset in cycle 4 of a five-term run, then a fresh two-term run
    t0 = cyc; d0 = done_count;
    step(1'b1, 8'd5, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1);
    step(1'b0, '0, 1'b1, 2);
    step(1'b0, '0, 1'b1, 3);
    RST_N = 1'b0;
    model_reset();
    step(1'b0, '0, 1'b1, 4);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 0);
    chk("t4_no_done", done_count - d0, 0);
    cep_count = 0;
    step(1'b1, 8'd2, 1'b0, 0);
    step(1'b0, '0, 1'b1, 2);
    step(1'b0, '0, 1'b1, 3);
    drain(1'b0, '0);
    chk("t4_cep_count", cep_count, 2);
    chk("t4_p", p_model, BIAS ? 105 : 5);

    // start pulses while busy are ignored
    cep_count = 0;
    step(1'b1, 8'd2, 1'b0, 0);
    step(1'b0, '0, 1'b1, 5);
    step(1'b1, 8'd9, 1'b1, 6);
    drain(1'b1, 8'd9);
    chk("t5_cep_count", cep_count, 2);
    step(1'b0, '0, 1'b0, 0);
    chk("t5_idle_after", cep_count, 2);

    // Maximum run length
    cep_count = 0;
    step(1'b1, 8'd255, 1'b0, 0);
    for (int i = 0; i < 255; i++) step(1'b0, '0, 1'b1, 1);
    drain(1'b0, '0);
    chk("t6_cep_count", cep_count, 255);
    chk("t6_p", p_model, BIAS ? 355 : 255);
    step(1'b0, '0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
